// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/mem/writeback with a timed memory handshake.
// Define MCU_ILLEGAL_TRAP_EN to trap on undefined instructions instead of treating them as NOPs.
module multi_cycle_control_unit #(
    parameter int WREN_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_sel,
    output logic              ir_load,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic [WREN_W-1:0] data_mem_wren,
    output logic              reg_file_wren,
    output logic              reg_file_dmux_select,
    output logic              reg_file_rmux_select,
    output logic              alu_mux_select,
    output logic [3:0]        alu_control,
    output logic [4:0]        alu_shamt,
    output logic              bus_error,
    output logic              illegal_op,
    output logic [2:0]        state
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]     CNT_MAX   = '1;
    localparam logic [CW-1:0]     TMO       = CW'(MEM_TIMEOUT);
    localparam logic [WREN_W-1:0] WREN_HALF = WREN_W'((64'd1 << (WREN_W / 2)) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
        S_MEM = 3'd4, S_WRITEBACK = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d, wait_inc;
    logic          bus_err_q, bus_err_d;
    logic          tmo_hit;

    logic [5:0] op, funct;
    logic       is_r, is_j, is_jr, is_imm, is_load, is_store, is_branch, legal, br_taken;
    logic [3:0] dec_alu;
    logic [WREN_W-1:0] st_wren;
    logic       unused_ok;

    assign op        = instruction[31:26];
    assign funct     = instruction[5:0];
    assign alu_shamt = instruction[10:6];
    assign unused_ok = ^instruction[25:11];
    assign state     = state_q;
    assign bus_error = bus_err_q;
    assign br_taken  = (op == 6'b000100 && alu_zero) || (op == 6'b000101 && !alu_zero);

    always_comb begin
        is_r = 1'b0; is_j = 1'b0; is_jr = 1'b0; is_imm = 1'b0; is_load = 1'b0;
        is_store = 1'b0; is_branch = 1'b0; legal = 1'b1; dec_alu = 4'b0000; st_wren = '0;
        case (op)
            6'b000000: begin
                is_r = 1'b1;
                case (funct)
                    6'b100100: dec_alu = 4'b0000;
                    6'b100101: dec_alu = 4'b0001;
                    6'b100110: dec_alu = 4'b0010;
                    6'b100111: dec_alu = 4'b0011;
                    6'b100001: dec_alu = 4'b0100;
                    6'b100000: dec_alu = 4'b0101;
                    6'b100011: dec_alu = 4'b0110;
                    6'b100010: dec_alu = 4'b0111;
                    6'b101010: dec_alu = 4'b1000;
                    6'b000000: dec_alu = 4'b1001;
                    6'b000010: dec_alu = 4'b1010;
                    6'b000011: dec_alu = 4'b1011;
                    6'b001000: is_jr = 1'b1;
                    default:   legal = 1'b0;
                endcase
            end
            6'b000010: is_j = 1'b1;
            6'b000100, 6'b000101: begin is_branch = 1'b1; dec_alu = 4'b0111; end
            6'b001000: begin is_imm = 1'b1; dec_alu = 4'b0101; end
            6'b001001: begin is_imm = 1'b1; dec_alu = 4'b0100; end
            6'b001010: begin is_imm = 1'b1; dec_alu = 4'b1000; end
            6'b001100: begin is_imm = 1'b1; dec_alu = 4'b0000; end
            6'b001101: begin is_imm = 1'b1; dec_alu = 4'b0001; end
            6'b001111: begin is_imm = 1'b1; dec_alu = 4'b1100; end
            6'b100011: begin is_load = 1'b1; dec_alu = 4'b0100; end
            6'b101000: begin is_store = 1'b1; dec_alu = 4'b0100; st_wren = WREN_W'(1); end
            6'b101001: begin is_store = 1'b1; dec_alu = 4'b0100; st_wren = WREN_HALF; end
            6'b101011: begin is_store = 1'b1; dec_alu = 4'b0100; st_wren = '1; end
            default: legal = 1'b0;
        endcase
    end

    // Counter saturates; ready on the reaching edge takes priority over timeout.
    assign wait_inc = (wait_q == CNT_MAX) ? wait_q : wait_q + CW'(1);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (wait_inc == TMO);

`ifdef MCU_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
    assign illegal_op = ill_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ill_q <= 1'b0;
        else        ill_q <= ill_d;
    end
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q; wait_d = wait_q; bus_err_d = bus_err_q;
`ifdef MCU_ILLEGAL_TRAP_EN
        ill_d = ill_q;
`endif
        mem_req = 1'b0; mem_sel = 1'b0; ir_load = 1'b0; pc_write = 1'b0; pc_src = 2'b00;
        data_mem_wren = '0; reg_file_wren = 1'b0; reg_file_dmux_select = 1'b0;
        reg_file_rmux_select = 1'b0; alu_mux_select = 1'b0; alu_control = 4'b0000;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1; pc_write = 1'b1; state_d = S_DECODE;
                end else if (tmo_hit) begin
                    bus_err_d = 1'b1; state_d = S_HALT;
                end else wait_d = wait_inc;
            end
            S_DECODE: begin
                if (!legal) begin
`ifdef MCU_ILLEGAL_TRAP_EN
                    ill_d = 1'b1; state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end else if (is_j) begin
                    pc_write = 1'b1; pc_src = 2'b01; state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_write = 1'b1; pc_src = 2'b10; state_d = S_FETCH;
                end else state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_control    = dec_alu;
                alu_mux_select = is_imm || is_load || is_store;
                if (is_branch) begin
                    pc_write = br_taken;
                    pc_src   = br_taken ? 2'b11 : 2'b00;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) state_d = S_MEM;
                else state_d = S_WRITEBACK;
            end
            S_MEM: begin
                mem_req = 1'b1; mem_sel = 1'b1; data_mem_wren = st_wren;
                if (mem_ready) state_d = is_load ? S_WRITEBACK : S_FETCH;
                else if (tmo_hit) begin
                    bus_err_d = 1'b1; state_d = S_HALT;
                end else wait_d = wait_inc;
            end
            S_WRITEBACK: begin
                reg_file_wren        = 1'b1;
                reg_file_dmux_select = is_load;
                reg_file_rmux_select = is_r;
                state_d              = S_FETCH;
            end
            default: ;
        endcase
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) wait_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction vector table with a scoreboard queue,
// plus hand sequences for reset, timeout, ready-vs-timeout race and illegal opcodes.
module tb_multi_cycle_control_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        alu_zero = 1'b0, mem_ready = 1'b1;
    logic        mem_req, mem_sel, ir_load, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  data_mem_wren;
    logic        reg_file_wren, reg_file_dmux_select, reg_file_rmux_select, alu_mux_select;
    logic [3:0]  alu_control;
    logic [4:0]  alu_shamt;
    logic        bus_error, illegal_op;
    logic [2:0]  state;

    int errors = 0, checks = 0;

    multi_cycle_control_unit #(.WREN_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src(pc_src), .data_mem_wren(data_mem_wren),
        .reg_file_wren(reg_file_wren), .reg_file_dmux_select(reg_file_dmux_select),
        .reg_file_rmux_select(reg_file_rmux_select), .alu_mux_select(alu_mux_select),
        .alu_control(alu_control), .alu_shamt(alu_shamt), .bus_error(bus_error),
        .illegal_op(illegal_op), .state(state));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int          mwait;
        int          cyc;     // 0 = cycle count not checked
        logic [3:0]  alu;
        logic        amux, pcw_dec;
        logic [1:0]  src_dec;
        logic        pcw_ex;
        logic [1:0]  src_ex;
        logic [3:0]  wren;
        logic        rfw, dmux, rmux;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic [31:0] i, logic z, int w, int c, logic [3:0] a,
                                logic am, logic pd, logic [1:0] sd, logic pe, logic [1:0] se,
                                logic [3:0] we, logic rf, logic dm, logic rm);
        vec_t v;
        v.name = n; v.instr = i; v.zero = z; v.mwait = w; v.cyc = c; v.alu = a; v.amux = am;
        v.pcw_dec = pd; v.src_dec = sd; v.pcw_ex = pe; v.src_ex = se; v.wren = we;
        v.rfw = rf; v.dmux = dm; v.rmux = rm;
        return v;
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int cyc = 0, mcnt = 0;
        bit done = 0, fetch_ok = 0, wren_seen = 0, wren_stable = 1, rfw_any = 0;
        logic pcw_dec = 0, pcw_ex = 0, amux = 0, dmux = 0, rmux = 0;
        logic [1:0] src_dec = 0, src_ex = 0;
        logic [3:0] alu = 0, wren = 0;
        exp_q.push_back(v);
        instruction = v.instr;
        alu_zero    = v.zero;
        while (!done && cyc < 60) begin
            if (state == 3'd4) begin mem_ready = (mcnt >= v.mwait); mcnt++; end
            else mem_ready = 1'b1;
            #1;
            if (cyc > 0 && state == 3'd1) done = 1;
            else begin
                rfw_any |= reg_file_wren;
                case (state)
                    3'd1: fetch_ok = mem_req && !mem_sel && ir_load && pc_write && pc_src == 2'b00;
                    3'd2: begin pcw_dec = pc_write; src_dec = pc_src; end
                    3'd3: begin alu = alu_control; amux = alu_mux_select; pcw_ex = pc_write; src_ex = pc_src; end
                    3'd4: begin
                        if (wren_seen && wren != data_mem_wren) wren_stable = 0;
                        wren = data_mem_wren; wren_seen = 1;
                    end
                    3'd5: begin dmux = reg_file_dmux_select; rmux = reg_file_rmux_select; end
                    default: ;
                endcase
                cyc++;
                @(negedge clk);
            end
        end
        e = exp_q.pop_front();
        chk({e.name, ".done"}, done, 1);
        chk({e.name, ".fetch"}, fetch_ok, 1);
        if (e.cyc != 0) chk({e.name, ".cycles"}, cyc, e.cyc);
        chk({e.name, ".alu"}, alu, e.alu);
        chk({e.name, ".amux"}, amux, e.amux);
        chk({e.name, ".dec_pc"}, {pcw_dec, src_dec}, {e.pcw_dec, e.src_dec});
        chk({e.name, ".ex_pc"}, {pcw_ex, src_ex}, {e.pcw_ex, e.src_ex});
        chk({e.name, ".wren"}, {wren_stable, wren}, {1'b1, e.wren});
        chk({e.name, ".rf"}, {rfw_any, dmux, rmux}, {e.rfw, e.dmux, e.rmux});
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0; mem_ready = rdy;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        //               name     instr        z  w  cyc alu  am pd sd pe se wren rf dm rm
        tbl.push_back(mk("add",   32'h00221820, 0, 0, 4, 4'h5, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(mk("lw",    32'h8C220004, 0, 3, 8, 4'h4, 1, 0, 0, 0, 0, 4'h0, 1, 1, 0));
        tbl.push_back(mk("sh",    32'hA4220004, 0, 2, 6, 4'h4, 1, 0, 0, 0, 0, 4'h3, 0, 0, 0));
        tbl.push_back(mk("beq_t", 32'h10220003, 1, 0, 0, 4'h7, 0, 0, 0, 1, 3, 4'h0, 0, 0, 0));
        tbl.push_back(mk("beq_n", 32'h10220003, 0, 0, 0, 4'h7, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk("bne_t", 32'h14220003, 0, 0, 0, 4'h7, 0, 0, 0, 1, 3, 4'h0, 0, 0, 0));
        tbl.push_back(mk("j",     32'h08000010, 0, 0, 2, 4'h0, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk("jr",    32'h03E00008, 0, 0, 2, 4'h0, 0, 1, 2, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk("ori",   32'h34220005, 0, 0, 4, 4'h1, 1, 0, 0, 0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk("sub",   32'h00221822, 0, 0, 4, 4'h7, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(mk("sll",   32'h00021080, 0, 0, 4, 4'h9, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(mk("slt",   32'h0022182A, 0, 0, 4, 4'h8, 0, 0, 0, 0, 0, 4'h0, 1, 0, 1));
        tbl.push_back(mk("lui",   32'h3C011234, 0, 0, 4, 4'hC, 1, 0, 0, 0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk("sw",    32'hAC220000, 0, 0, 4, 4'h4, 1, 0, 0, 0, 0, 4'hF, 0, 0, 0));
        tbl.push_back(mk("sb",    32'hA0220000, 0, 1, 5, 4'h4, 1, 0, 0, 0, 0, 4'h1, 0, 0, 0));
`ifndef MCU_ILLEGAL_TRAP_EN
        tbl.push_back(mk("badop", 32'hFC000000, 0, 0, 2, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk("badfn", 32'h0000003F, 0, 0, 2, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
`endif

        // Reset state: everything zero except shamt, which follows the instruction.
        instruction = 32'h000007C0;
        @(negedge clk);
        chk("rst.state", state, 0);
        chk("rst.flags", {bus_error, illegal_op}, 0);
        chk("rst.ctrl", {mem_req, mem_sel, ir_load, pc_write, pc_src, data_mem_wren, reg_file_wren,
                         reg_file_dmux_select, reg_file_rmux_select, alu_mux_select, alu_control}, 0);
        chk("rst.shamt", alu_shamt, 5'd31);
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot.fetch", {state, mem_req, mem_sel}, {3'd1, 1'b1, 1'b0});

        foreach (tbl[k]) run_vec(tbl[k]);

`ifdef MCU_ILLEGAL_TRAP_EN
        instruction = 32'hFC000000; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("trap.state", state, 7);
        chk("trap.flag", illegal_op, 1);
        repeat (3) @(negedge clk);
        chk("trap.hold", {state, mem_req, reg_file_wren, data_mem_wren}, {3'd7, 6'd0});
`else
        chk("nop.flag", illegal_op, 0);
`endif

        // Timeout: ready stuck low in FETCH halts after exactly 15 wait cycles.
        begin
            int n = 0;
            do_reset(1'b0);
            while (state == 3'd1 && n < 40) begin n++; @(negedge clk); end
            chk("tmo.cycles", n, 15);
            chk("tmo.halt", {state, bus_error, mem_req}, {3'd6, 1'b1, 1'b0});
            mem_ready = 1'b1;
            repeat (3) @(negedge clk);
            chk("tmo.stuck", {state, bus_error}, {3'd6, 1'b1});
            rst_n = 1'b0; #1;
            chk("tmo.clear", {state, bus_error}, {3'd0, 1'b0});
        end

        // Ready arriving on the edge the counter reaches the limit wins.
        do_reset(1'b0);
        repeat (14) @(negedge clk);
        chk("race.wait", {state, bus_error}, {3'd1, 1'b0});
        mem_ready = 1'b1;
        @(negedge clk);
        chk("race.win", {state, bus_error}, {3'd2, 1'b0});

        // Reset mid-handshake drops mem_req without waiting for a clock edge.
        do_reset(1'b0);
        chk("async.pre", {state, mem_req}, {3'd1, 1'b1});
        #3 rst_n = 1'b0;
        #1 chk("async.drop", {state, mem_req}, {3'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
